// File: rtl/dlsc_pcie_inbound_demux.sv
// dlsc_pcie_inbound_demux
// Parses a 32-bit inbound PCIe TLP stream (3DW/4DW headers) and steers
// memory reads, memory writes and completions onto separate command and
// payload channels. Unsupported TLPs and requests that miss every enabled
// BAR are consumed silently. Outstanding reads are counted to pace the core
// through rx_np_ok.
// Optional build macro: DLSC_PCIE_INBOUND_ERR_DROP_EN
//   defined   -> rx_err on a header beat discards the TLP; rx_err on a payload
//                beat ends the payload early (that beat carries *p_last).
//   undefined -> rx_err is ignored.

module dlsc_pcie_inbound_demux #(
  parameter int         NP_MAX   = 8,
  parameter int         ADDR_W   = 64,
  parameter logic [6:0] BAR_MASK = 7'h7F
) (
  input  logic              clk,
  input  logic              rst_n,

  output logic              rx_ready,
  input  logic              rx_valid,
  input  logic              rx_last,
  input  logic [31:0]       rx_data,
  input  logic [6:0]        rx_bar,
  input  logic              rx_err,
  output logic              rx_np_ok,

  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [9:0]        rd_length,
  output logic [7:0]        rd_tag,
  output logic [3:0]        rd_be_last,
  output logic [3:0]        rd_be_first,
  output logic [ADDR_W-3:0] rd_addr,
  output logic [6:0]        rd_bar,
  input  logic              rd_done,

  input  logic              wr_ready,
  output logic              wr_valid,
  output logic [9:0]        wr_length,
  output logic [3:0]        wr_be_last,
  output logic [3:0]        wr_be_first,
  output logic [ADDR_W-3:0] wr_addr,
  output logic [6:0]        wr_bar,

  input  logic              wrp_ready,
  output logic              wrp_valid,
  output logic              wrp_last,
  output logic [31:0]       wrp_data,

  input  logic              cpl_ready,
  output logic              cpl_valid,
  output logic [2:0]        cpl_status,
  output logic              cpl_bcm,
  output logic [11:0]       cpl_bytes,
  output logic [7:0]        cpl_tag,

  input  logic              cplp_ready,
  output logic              cplp_valid,
  output logic              cplp_last,
  output logic [31:0]       cplp_data
);

  typedef enum logic [2:0] {
    ST_H0, ST_H1, ST_H2, ST_H3, ST_CMD, ST_PL, ST_DISC
  } state_t;

  typedef enum logic [1:0] {
    K_RD, K_WR, K_CPL, K_UNS
  } kind_t;

  localparam logic [8:0] NP_LIMIT = 9'(NP_MAX);

  state_t      state, state_next;
  kind_t       kind, dw0_kind;
  logic        active;
  logic        is_4dw, has_pl, hdr_last;
  logic [9:0]  len;
  logic [10:0] rem;
  logic [7:0]  tag;
  logic [3:0]  be_last, be_first;
  logic [31:0] addr_hi;
  logic [29:0] addr_lo;
  logic [61:0] addr_full;
  logic [6:0]  bar;
  logic [2:0]  status;
  logic        bcm;
  logic [11:0] bytes;

  logic        pl_valid, pl_last, pl_is_cpl, pl_ready, pl_free;
  logic [31:0] pl_data;

  logic [7:0]  np_count, np_count_next;
  logic        np_inc, np_dec;

  logic        rx_beat, err_in, bar_hit, dw0_drop;
  logic        cmd_ready, cmd_accept;
  logic [1:0]  dw0_fmt;
  logic [4:0]  dw0_type;

`ifdef DLSC_PCIE_INBOUND_ERR_DROP_EN
  assign err_in = rx_err;
`else
  logic unused_rx_err;
  assign err_in        = 1'b0;
  assign unused_rx_err = rx_err;
`endif

  assign rx_beat  = rx_valid && rx_ready;
  assign dw0_fmt  = rx_data[30:29];
  assign dw0_type = rx_data[28:24];
  assign bar_hit  = |(rx_bar & BAR_MASK);

  // Classify the first header DW and decide whether the TLP is kept
  always_comb begin
    dw0_kind = K_UNS;
    if (dw0_type == 5'b00000) begin
      dw0_kind = dw0_fmt[1] ? K_WR : K_RD;
    end else if (dw0_type == 5'b01010 && !dw0_fmt[0]) begin
      dw0_kind = K_CPL;
    end
    dw0_drop = (dw0_kind == K_UNS) || err_in ||
               ((dw0_kind != K_CPL) && !bar_hit);
  end

  assign pl_ready = pl_is_cpl ? cplp_ready : wrp_ready;
  assign pl_free  = !pl_valid || pl_ready;

  // Select the ready of whichever command channel this TLP targets
  always_comb begin
    cmd_ready = 1'b0;
    case (kind)
      K_RD:    cmd_ready = rd_ready;
      K_WR:    cmd_ready = wr_ready;
      K_CPL:   cmd_ready = cpl_ready;
      default: cmd_ready = 1'b0;
    endcase
  end

  assign cmd_accept = (state == ST_CMD) && cmd_ready;

  // Input stall: header/discard always accept, command stalls, payload
  // accepts whenever the one-entry output register can take a beat
  always_comb begin
    rx_ready = 1'b0;
    if (active) begin
      case (state)
        ST_H0, ST_H1, ST_H2, ST_H3, ST_DISC: rx_ready = 1'b1;
        ST_PL:                               rx_ready = pl_free;
        default:                             rx_ready = 1'b0;
      endcase
    end
  end

  // Next-state logic for the TLP parser
  always_comb begin
    state_next = state;
    case (state)
      ST_H0: begin
        if (rx_beat) begin
          if (rx_last)       state_next = ST_H0;
          else if (dw0_drop) state_next = ST_DISC;
          else               state_next = ST_H1;
        end
      end
      ST_H1: begin
        if (rx_beat) begin
          if (rx_last)     state_next = ST_H0;
          else if (err_in) state_next = ST_DISC;
          else             state_next = ST_H2;
        end
      end
      ST_H2: begin
        if (rx_beat) begin
          if (kind != K_CPL && is_4dw) begin
            if (rx_last)     state_next = ST_H0;
            else if (err_in) state_next = ST_DISC;
            else             state_next = ST_H3;
          end else begin
            if (err_in) state_next = rx_last ? ST_H0 : ST_DISC;
            else        state_next = ST_CMD;
          end
        end
      end
      ST_H3: begin
        if (rx_beat) begin
          if (err_in) state_next = rx_last ? ST_H0 : ST_DISC;
          else        state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_ready) begin
          if (hdr_last)    state_next = ST_H0;
          else if (has_pl) state_next = ST_PL;
          else             state_next = ST_DISC;
        end
      end
      ST_PL: begin
        if (rx_beat) begin
          if (rx_last)                          state_next = ST_H0;
          else if (rem == 11'd1 || err_in)      state_next = ST_DISC;
          else                                  state_next = ST_PL;
        end
      end
      ST_DISC: begin
        if (rx_beat && rx_last) state_next = ST_H0;
      end
      default: state_next = ST_H0;
    endcase
  end

  // Parser state register; 'active' holds rx_ready low until out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_H0;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
    end
  end

  // Capture header fields beat by beat and track the remaining payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind     <= K_UNS;
      is_4dw   <= 1'b0;
      has_pl   <= 1'b0;
      hdr_last <= 1'b0;
      len      <= '0;
      rem      <= '0;
      tag      <= '0;
      be_last  <= '0;
      be_first <= '0;
      addr_hi  <= '0;
      addr_lo  <= '0;
      bar      <= '0;
      status   <= '0;
      bcm      <= 1'b0;
      bytes    <= '0;
    end else begin
      if (rx_beat) begin
        case (state)
          ST_H0: begin
            kind     <= dw0_kind;
            is_4dw   <= dw0_fmt[0];
            has_pl   <= dw0_fmt[1];
            len      <= rx_data[9:0];
            bar      <= rx_bar;
            addr_hi  <= '0;
            hdr_last <= 1'b0;
          end
          ST_H1: begin
            if (kind == K_CPL) begin
              status <= rx_data[15:13];
              bcm    <= rx_data[12];
              bytes  <= rx_data[11:0];
            end else begin
              tag      <= rx_data[15:8];
              be_last  <= rx_data[7:4];
              be_first <= rx_data[3:0];
            end
          end
          ST_H2: begin
            hdr_last <= rx_last;
            if (kind == K_CPL) tag     <= rx_data[15:8];
            else if (is_4dw)   addr_hi <= rx_data;
            else               addr_lo <= rx_data[31:2];
          end
          ST_H3: begin
            hdr_last <= rx_last;
            addr_lo  <= rx_data[31:2];
          end
          ST_PL: begin
            rem <= rem - 11'd1;
          end
          default: ;
        endcase
      end
      if (cmd_accept) begin
        rem <= (len == 10'd0) ? 11'd1024 : {1'b0, len};
      end
    end
  end

  // One-entry payload output register shared by write and completion data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl_valid  <= 1'b0;
      pl_last   <= 1'b0;
      pl_is_cpl <= 1'b0;
      pl_data   <= '0;
    end else if (state == ST_PL && rx_beat) begin
      pl_valid  <= 1'b1;
      pl_data   <= rx_data;
      pl_last   <= (rem == 11'd1) || rx_last || err_in;
      pl_is_cpl <= (kind == K_CPL);
    end else if (pl_ready) begin
      pl_valid <= 1'b0;
    end
  end

  assign np_inc = rd_valid && rd_ready && (np_count != 8'hFF);
  assign np_dec = rd_done && (np_count != 8'd0);

  // Outstanding read count after this cycle's issue/retire events
  always_comb begin
    np_count_next = np_count;
    if (np_inc && !np_dec)      np_count_next = np_count + 8'd1;
    else if (!np_inc && np_dec) np_count_next = np_count - 8'd1;
  end

  // Non-posted credit tracking; keeps headroom for one read already in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      np_count <= '0;
      rx_np_ok <= 1'b1;
    end else begin
      np_count <= np_count_next;
      rx_np_ok <= ({1'b0, np_count_next} + 9'd1) < NP_LIMIT;
    end
  end

  assign addr_full   = {addr_hi, addr_lo};

  assign rd_valid    = (state == ST_CMD) && (kind == K_RD);
  assign rd_length   = len;
  assign rd_tag      = tag;
  assign rd_be_last  = be_last;
  assign rd_be_first = be_first;
  assign rd_addr     = addr_full[ADDR_W-3:0];
  assign rd_bar      = bar;

  assign wr_valid    = (state == ST_CMD) && (kind == K_WR);
  assign wr_length   = len;
  assign wr_be_last  = be_last;
  assign wr_be_first = be_first;
  assign wr_addr     = addr_full[ADDR_W-3:0];
  assign wr_bar      = bar;

  assign cpl_valid   = (state == ST_CMD) && (kind == K_CPL);
  assign cpl_status  = status;
  assign cpl_bcm     = bcm;
  assign cpl_bytes   = bytes;
  assign cpl_tag     = tag;

  assign wrp_valid   = pl_valid && !pl_is_cpl;
  assign wrp_last    = pl_last;
  assign wrp_data    = pl_data;

  assign cplp_valid  = pl_valid && pl_is_cpl;
  assign cplp_last   = pl_last;
  assign cplp_data   = pl_data;

endmodule

// File: tb/tb_dlsc_pcie_inbound_demux.sv
// tb_dlsc_pcie_inbound_demux
// Directed self-checking bench for the inbound TLP demux (NP_MAX=4).

module tb_dlsc_pcie_inbound_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_ready, rx_valid = 1'b0, rx_last = 1'b0, rx_err = 1'b0;
  logic [31:0] rx_data = '0;
  logic [6:0]  rx_bar = 7'h01;
  logic        rx_np_ok;
  logic        rd_ready = 1'b1, rd_valid, rd_done = 1'b0;
  logic [9:0]  rd_length, wr_length;
  logic [7:0]  rd_tag, cpl_tag;
  logic [3:0]  rd_be_last, rd_be_first, wr_be_last, wr_be_first;
  logic [61:0] rd_addr, wr_addr;
  logic [6:0]  rd_bar, wr_bar;
  logic        wr_ready = 1'b1, wr_valid;
  logic        wrp_ready = 1'b1, wrp_valid, wrp_last;
  logic [31:0] wrp_data, cplp_data;
  logic        cpl_ready = 1'b1, cpl_valid, cpl_bcm;
  logic [2:0]  cpl_status;
  logic [11:0] cpl_bytes;
  logic        cplp_ready = 1'b1, cplp_valid, cplp_last;

  int vectors = 0;
  int miscompares = 0;

  int          valid_seen = 0, rx_beats = 0, wr_cmds = 0, rd_accepts = 0, cpl_cmds = 0;
  logic [61:0] wr_addr_log;
  logic [9:0]  wr_len_log;
  logic [6:0]  wr_bar_log;
  logic [23:0] cpl_log;
  logic [32:0] wrp_q[$];
  logic [32:0] cplp_q[$];

  dlsc_pcie_inbound_demux #(.NP_MAX(4), .ADDR_W(64), .BAR_MASK(7'h7F)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_last(rx_last), .rx_data(rx_data),
    .rx_bar(rx_bar), .rx_err(rx_err), .rx_np_ok(rx_np_ok),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_length(rd_length), .rd_tag(rd_tag),
    .rd_be_last(rd_be_last), .rd_be_first(rd_be_first), .rd_addr(rd_addr), .rd_bar(rd_bar),
    .rd_done(rd_done),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_length(wr_length), .wr_be_last(wr_be_last),
    .wr_be_first(wr_be_first), .wr_addr(wr_addr), .wr_bar(wr_bar),
    .wrp_ready(wrp_ready), .wrp_valid(wrp_valid), .wrp_last(wrp_last), .wrp_data(wrp_data),
    .cpl_ready(cpl_ready), .cpl_valid(cpl_valid), .cpl_status(cpl_status), .cpl_bcm(cpl_bcm),
    .cpl_bytes(cpl_bytes), .cpl_tag(cpl_tag),
    .cplp_ready(cplp_ready), .cplp_valid(cplp_valid), .cplp_last(cplp_last), .cplp_data(cplp_data)
  );

  always #5 clk = ~clk;

  // Record every handshake one half-cycle before the edge that completes it
  always @(negedge clk) begin
    if (rd_valid || wr_valid || cpl_valid || wrp_valid || cplp_valid) valid_seen++;
    if (rx_valid && rx_ready) rx_beats++;
    if (rd_valid && rd_ready) rd_accepts++;
    if (wr_valid && wr_ready) begin
      wr_cmds++;
      wr_addr_log = wr_addr;
      wr_len_log  = wr_length;
      wr_bar_log  = wr_bar;
    end
    if (cpl_valid && cpl_ready) begin
      cpl_cmds++;
      cpl_log = {cpl_status, cpl_bcm, cpl_bytes, cpl_tag};
    end
    if (wrp_valid && wrp_ready)   wrp_q.push_back({wrp_last, wrp_data});
    if (cplp_valid && cplp_ready) cplp_q.push_back({cplp_last, cplp_data});
  end

  // Global time limit so the run can never hang
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_logs();
    valid_seen = 0; rx_beats = 0; wr_cmds = 0; rd_accepts = 0; cpl_cmds = 0;
    wrp_q.delete(); cplp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [31:0] d, input logic last, input logic err,
                           input logic [6:0] bar);
    int waited = 0;
    rx_valid = 1'b1; rx_data = d; rx_last = last; rx_err = err; rx_bar = bar;
    @(negedge clk);
    while (!rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      vectors++; miscompares++;
      $display("[TB] FAIL rx_accept_timeout: beat %08h not accepted, rx_ready=%0b required 1", d, rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %0b required 0", rx_ready); end
    vectors++; if (rx_np_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_np_ok: got %0b required 1", rx_np_ok); end
    vectors++;
    if ({rd_valid, wr_valid, cpl_valid, wrp_valid, cplp_valid} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valids: got %05b required 00000", {rd_valid, wr_valid, cpl_valid, wrp_valid, cplp_valid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_rx_ready: got %0b required 1", rx_ready); end
    vectors++; if (rx_np_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_np_ok: got %0b required 1", rx_np_ok); end
    @(posedge clk); #1;
  endtask

  task automatic test_mwr_3dw();
    clear_logs();
    send_beat(32'h4000_0002, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00FF, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_1000, 1'b0, 1'b0, 7'h01);
    send_beat(32'hDEAD_0001, 1'b0, 1'b0, 7'h01);
    send_beat(32'hDEAD_0002, 1'b1, 1'b0, 7'h01);
    idle(4);
    vectors++; if (wr_cmds != 1) begin miscompares++; $display("[TB] FAIL mwr_cmd_count: got %0d required 1", wr_cmds); end
    vectors++; if (wr_addr_log !== 62'h400) begin miscompares++; $display("[TB] FAIL mwr_addr: got %0h required 400", wr_addr_log); end
    vectors++; if (wr_len_log !== 10'd2) begin miscompares++; $display("[TB] FAIL mwr_len: got %0d required 2", wr_len_log); end
    vectors++; if (wr_bar_log !== 7'h01) begin miscompares++; $display("[TB] FAIL mwr_bar: got %0h required 01", wr_bar_log); end
    vectors++; if (wrp_q.size() != 2) begin miscompares++; $display("[TB] FAIL mwr_beats: got %0d required 2", wrp_q.size()); end
    if (wrp_q.size() == 2) begin
      vectors++; if (wrp_q[0] !== {1'b0, 32'hDEAD_0001}) begin miscompares++; $display("[TB] FAIL mwr_beat0: got %09h required 0DEAD0001", wrp_q[0]); end
      vectors++; if (wrp_q[1] !== {1'b1, 32'hDEAD_0002}) begin miscompares++; $display("[TB] FAIL mwr_beat1: got %09h required 1DEAD0002", wrp_q[1]); end
    end
    vectors++; if (rd_accepts != 0 || cpl_cmds != 0) begin miscompares++; $display("[TB] FAIL mwr_stray_cmd: got rd=%0d cpl=%0d required 0/0", rd_accepts, cpl_cmds); end
  endtask

  task automatic test_mrd_4dw_stall();
    clear_logs();
    rd_ready = 1'b0;
    send_beat(32'h2000_0001, 1'b0, 1'b0, 7'h02);
    send_beat(32'h0000_3A0F, 1'b0, 1'b0, 7'h02);
    send_beat(32'h0000_0001, 1'b0, 1'b0, 7'h02);
    send_beat(32'h0000_0040, 1'b1, 1'b0, 7'h02);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mrd_hold_valid[%0d]: got %0b required 1", i, rd_valid); end
      vectors++; if (rd_tag !== 8'h3A) begin miscompares++; $display("[TB] FAIL mrd_hold_tag[%0d]: got %0h required 3a", i, rd_tag); end
      vectors++; if (rd_addr !== 62'h4000_0010) begin miscompares++; $display("[TB] FAIL mrd_hold_addr[%0d]: got %0h required 40000010", i, rd_addr); end
      vectors++;
      if ({rd_length, rd_be_last, rd_be_first, rd_bar} !== {10'd1, 4'h0, 4'hF, 7'h02}) begin
        miscompares++;
        $display("[TB] FAIL mrd_hold_fields[%0d]: got len=%0d bel=%0h bef=%0h bar=%0h required 1/0/f/02", i, rd_length, rd_be_last, rd_be_first, rd_bar);
      end
    end
    @(posedge clk); #1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(negedge clk);
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mrd_release: got %0b required 0", rd_valid); end
    vectors++; if (rd_accepts != 1) begin miscompares++; $display("[TB] FAIL mrd_accepts: got %0d required 1", rd_accepts); end
    @(posedge clk); #1;
    rd_ready = 1'b1;
    rd_done = 1'b1;
    @(posedge clk); #1;
    rd_done = 1'b0;
    idle(1);
  endtask

  task automatic test_np_tracking();
    int start;
    int waited;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      start = rd_accepts;
      send_beat(32'h0000_0001, 1'b0, 1'b0, 7'h01);
      send_beat({16'h0, 8'h40 + 8'(i), 8'h0F}, 1'b0, 1'b0, 7'h01);
      send_beat(32'h0000_2000, 1'b1, 1'b0, 7'h01);
      waited = 0;
      while (rd_accepts == start && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      if (rd_accepts == start) begin
        vectors++; miscompares++;
        $display("[TB] FAIL np_rd_timeout[%0d]: got 0 accepts required 1", i);
      end
      @(negedge clk);
      vectors++;
      if (rx_np_ok !== ((i + 2) < 4)) begin
        miscompares++;
        $display("[TB] FAIL np_ok_after_rd[%0d]: got %0b required %0b", i, rx_np_ok, ((i + 2) < 4));
      end
      @(posedge clk); #1;
    end
    rd_done = 1'b1;
    @(posedge clk); #1;
    rd_done = 1'b0;
    @(negedge clk);
    vectors++; if (rx_np_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL np_ok_after_done: got %0b required 1", rx_np_ok); end
    @(posedge clk); #1;
    rd_done = 1'b1;
    idle(3);
    rd_done = 1'b0;
    @(negedge clk);
    vectors++; if (rx_np_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL np_ok_done_at_zero: got %0b required 1", rx_np_ok); end
    @(posedge clk); #1;
  endtask

  task automatic test_completion();
    clear_logs();
    send_beat(32'h4A00_0001, 1'b0, 1'b0, 7'h00);
    send_beat(32'h0100_0004, 1'b0, 1'b0, 7'h00);
    send_beat(32'h0000_1100, 1'b0, 1'b0, 7'h00);
    send_beat(32'hCAFE_F00D, 1'b1, 1'b0, 7'h00);
    idle(4);
    vectors++; if (cpl_cmds != 1) begin miscompares++; $display("[TB] FAIL cpld_cmd_count: got %0d required 1", cpl_cmds); end
    vectors++; if (cpl_log !== {3'b000, 1'b0, 12'h004, 8'h11}) begin miscompares++; $display("[TB] FAIL cpld_fields: got %06h required 004011", cpl_log); end
    vectors++; if (cplp_q.size() != 1) begin miscompares++; $display("[TB] FAIL cpld_beats: got %0d required 1", cplp_q.size()); end
    if (cplp_q.size() == 1) begin
      vectors++; if (cplp_q[0] !== {1'b1, 32'hCAFE_F00D}) begin miscompares++; $display("[TB] FAIL cpld_beat0: got %09h required 1CAFEF00D", cplp_q[0]); end
    end
    vectors++; if (wr_cmds != 0 || wrp_q.size() != 0) begin miscompares++; $display("[TB] FAIL cpld_stray_wr: got wr=%0d wrp=%0d required 0/0", wr_cmds, wrp_q.size()); end
    clear_logs();
    send_beat(32'h0A00_0000, 1'b0, 1'b0, 7'h00);
    send_beat(32'h0000_5123, 1'b0, 1'b0, 7'h00);
    send_beat(32'h0000_7E00, 1'b1, 1'b0, 7'h00);
    idle(4);
    vectors++; if (cpl_cmds != 1) begin miscompares++; $display("[TB] FAIL cpl_cmd_count: got %0d required 1", cpl_cmds); end
    vectors++; if (cpl_log !== {3'b010, 1'b1, 12'h123, 8'h7E}) begin miscompares++; $display("[TB] FAIL cpl_fields: got %06h required 51237e", cpl_log); end
    vectors++; if (cplp_q.size() != 0) begin miscompares++; $display("[TB] FAIL cpl_nodata_beats: got %0d required 0", cplp_q.size()); end
  endtask

  task automatic test_discard();
    clear_logs();
    send_beat(32'h4200_0001, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_000F, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_3000, 1'b0, 1'b0, 7'h01);
    send_beat(32'h1234_5678, 1'b1, 1'b0, 7'h01);
    idle(3);
    vectors++; if (rx_beats != 4) begin miscompares++; $display("[TB] FAIL unsup_beats: got %0d required 4", rx_beats); end
    vectors++; if (valid_seen != 0) begin miscompares++; $display("[TB] FAIL unsup_valids: got %0d required 0", valid_seen); end
    clear_logs();
    send_beat(32'h4000_0001, 1'b0, 1'b0, 7'h00);
    send_beat(32'h0000_00FF, 1'b0, 1'b0, 7'h00);
    send_beat(32'h0000_1000, 1'b0, 1'b0, 7'h00);
    send_beat(32'h5555_AAAA, 1'b1, 1'b0, 7'h00);
    idle(3);
    vectors++; if (valid_seen != 0) begin miscompares++; $display("[TB] FAIL barmiss_valids: got %0d required 0", valid_seen); end
    @(negedge clk);
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL discard_back_idle: got %0b required 1", rx_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_length_mismatch();
    clear_logs();
    send_beat(32'h4000_0004, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00FF, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_1000, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00A0, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00A1, 1'b1, 1'b0, 7'h01);
    idle(3);
    vectors++; if (wrp_q.size() != 2) begin miscompares++; $display("[TB] FAIL early_beats: got %0d required 2", wrp_q.size()); end
    if (wrp_q.size() == 2) begin
      vectors++; if (wrp_q[1] !== {1'b1, 32'h0000_00A1}) begin miscompares++; $display("[TB] FAIL early_forced_last: got %09h required 1000000A1", wrp_q[1]); end
    end
    clear_logs();
    send_beat(32'h4000_0001, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00FF, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_2000, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00B0, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00B1, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00B2, 1'b1, 1'b0, 7'h01);
    idle(3);
    vectors++; if (rx_beats != 6) begin miscompares++; $display("[TB] FAIL late_beats_consumed: got %0d required 6", rx_beats); end
    vectors++; if (wrp_q.size() != 1) begin miscompares++; $display("[TB] FAIL late_beats: got %0d required 1", wrp_q.size()); end
    if (wrp_q.size() == 1) begin
      vectors++; if (wrp_q[0] !== {1'b1, 32'h0000_00B0}) begin miscompares++; $display("[TB] FAIL late_last: got %09h required 1000000B0", wrp_q[0]); end
    end
  endtask

  task automatic test_err_drop();
    int exp_cmds;
    int exp_beats;
`ifdef DLSC_PCIE_INBOUND_ERR_DROP_EN
    exp_cmds = 0; exp_beats = 0;
`else
    exp_cmds = 1; exp_beats = 1;
`endif
    clear_logs();
    send_beat(32'h4000_0001, 1'b0, 1'b1, 7'h01);
    send_beat(32'h0000_00FF, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_4000, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00C0, 1'b1, 1'b0, 7'h01);
    idle(4);
    vectors++; if (wr_cmds != exp_cmds) begin miscompares++; $display("[TB] FAIL err_cmds: got %0d required %0d", wr_cmds, exp_cmds); end
    vectors++; if (wrp_q.size() != exp_beats) begin miscompares++; $display("[TB] FAIL err_beats: got %0d required %0d", wrp_q.size(), exp_beats); end
  endtask

  task automatic test_reset_mid_tlp();
    clear_logs();
    send_beat(32'h4000_0001, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00FF, 1'b0, 1'b0, 7'h01);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_rx_ready: got %0b required 0", rx_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_beat(32'h4000_0001, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00FF, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_3000, 1'b0, 1'b0, 7'h01);
    send_beat(32'h0000_00D0, 1'b1, 1'b0, 7'h01);
    idle(4);
    vectors++; if (wr_cmds != 1) begin miscompares++; $display("[TB] FAIL midrst_cmds: got %0d required 1", wr_cmds); end
    vectors++; if (wr_addr_log !== 62'hC00) begin miscompares++; $display("[TB] FAIL midrst_addr: got %0h required c00", wr_addr_log); end
  endtask

  initial begin
    $display("[TB] starting tb_dlsc_pcie_inbound_demux");
    test_reset();
    test_mwr_3dw();
    test_mrd_4dw_stall();
    test_np_tracking();
    test_completion();
    test_discard();
    test_length_mismatch();
    test_err_drop();
    test_reset_mid_tlp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
